// File: rtl/add_in_pkg_hdl.sv
// Shared types and width helpers for the add_in arbitrated adder pipeline.
package add_in_pkg_hdl;

    typedef enum logic [1:0] {
        ADD      = 2'b00,
        SUB      = 2'b01,
        ACC      = 2'b10,
        ACC_LOAD = 2'b11
    } add_op_t;

    function automatic int res_w(input int add_width);
        return add_width + 1;
    endfunction

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Control half of a stage payload; operand/channel fields are sized by the user module.
    typedef struct packed {
        logic    vld;
        add_op_t op;
    } stage_ctl_t;

endpackage

// File: rtl/add_in_rr_arb.sv
// Round-robin arbiter: scans requests starting at the pointer, grants at most one per cycle.
module add_in_rr_arb
    import add_in_pkg_hdl::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   id,
    output logic              any
);

    logic [CH_W-1:0] ptr;
    int              scan_idx;

    always_comb begin
        gnt      = '0;
        id       = '0;
        any      = 1'b0;
        scan_idx = 0;
        if (advance) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scan_idx = int'(ptr) + i;
                if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
                if (!any && req[scan_idx]) begin
                    any           = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    id            = CH_W'(scan_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (int'(id) == NUM_CH - 1) ? '0 : id + CH_W'(1);
        end
    end

endmodule

// File: rtl/add_in_arb_pipe.sv
// NUM_CH requesters round-robin into a shared 2-stage add/sub/accumulate pipeline.
// Define ADD_IN_SAT_EN to saturate SUB underflow to 0 and ACC wrap to all-ones.
module add_in_arb_pipe
    import add_in_pkg_hdl::*;
#(
    parameter  int ADD_WIDTH = 4,
    parameter  int NUM_CH    = 4,
    localparam int CH_W      = ch_w(NUM_CH),
    localparam int RW        = res_w(ADD_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic [NUM_CH*ADD_WIDTH-1:0] in_a,
    input  logic [NUM_CH*ADD_WIDTH-1:0] in_b,
    input  logic [NUM_CH*2-1:0]         in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RW-1:0]               out_sum,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_ovf,
    output logic                        busy
);

    stage_ctl_t             s1_ctl;
    logic [ADD_WIDTH-1:0]   s1_a;
    logic [ADD_WIDTH-1:0]   s1_b;
    logic [CH_W-1:0]        s1_ch;

    logic                   s1_move;
    logic                   grant_en;
    logic                   any_gnt;
    logic [NUM_CH-1:0]      gnt;
    logic [CH_W-1:0]        gnt_id;
    logic [ADD_WIDTH-1:0]   sel_a;
    logic [ADD_WIDTH-1:0]   sel_b;
    add_op_t                sel_op;

    logic [RW-1:0]          acc [NUM_CH];
    logic [RW-1:0]          a_e;
    logic [RW-1:0]          b_e;
    logic [RW-1:0]          acc_cur;
    logic [RW:0]            acc_full;
    logic [RW-1:0]          res_sum;
    logic                   res_ovf;
    logic                   acc_we;

    // S1 frees up in the same cycle it hands off, which is what gives 1/cycle throughput.
    assign s1_move  = s1_ctl.vld & (~out_valid | out_ready);
    assign grant_en = rst & (~s1_ctl.vld | s1_move);
    assign in_ready = gnt;
    assign busy     = s1_ctl.vld | out_valid;

    add_in_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (grant_en),
        .gnt     (gnt),
        .id      (gnt_id),
        .any     (any_gnt)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ADD;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_a  = in_a[i*ADD_WIDTH +: ADD_WIDTH];
                sel_b  = in_b[i*ADD_WIDTH +: ADD_WIDTH];
                sel_op = add_op_t'(in_op[i*2 +: 2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_ctl <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_ch  <= '0;
        end else if (any_gnt) begin
            s1_ctl <= '{vld: 1'b1, op: sel_op};
            s1_a   <= sel_a;
            s1_b   <= sel_b;
            s1_ch  <= gnt_id;
        end else if (s1_move) begin
            s1_ctl.vld <= 1'b0;
        end
    end

    // Result is formed from S1 contents; the accumulator is read here and written on the move.
    always_comb begin
        a_e      = {1'b0, s1_a};
        b_e      = {1'b0, s1_b};
        acc_cur  = acc[s1_ch];
        acc_full = {1'b0, acc_cur} + {2'b00, s1_a};
        res_sum  = '0;
        res_ovf  = 1'b0;
        acc_we   = 1'b0;
        case (s1_ctl.op)
            ADD: begin
                res_sum = a_e + b_e;
                res_ovf = res_sum[RW-1];
            end
            SUB: begin
                res_ovf = (s1_a < s1_b);
`ifdef ADD_IN_SAT_EN
                res_sum = res_ovf ? '0 : a_e - b_e;
`else
                res_sum = a_e - b_e;
`endif
            end
            ACC: begin
                res_ovf = acc_full[RW];
`ifdef ADD_IN_SAT_EN
                res_sum = res_ovf ? '1 : acc_full[RW-1:0];
`else
                res_sum = acc_full[RW-1:0];
`endif
                acc_we  = 1'b1;
            end
            ACC_LOAD: begin
                res_sum = a_e + b_e;
                acc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else if (s1_move && acc_we) begin
            acc[s1_ch] <= res_sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ch    <= '0;
            out_ovf   <= 1'b0;
        end else if (s1_move) begin
            out_valid <= 1'b1;
            out_sum   <= res_sum;
            out_ch    <= s1_ch;
            out_ovf   <= res_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_in_arb_pipe.sv
// Directed bench for add_in_arb_pipe: vector table plus arbitration, stall and reset sequences.
module tb_add_in_arb_pipe;

    localparam int W = 4;
    localparam int N = 4;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_ACC = 2;
    localparam int OP_LD  = 3;

`ifdef ADD_IN_SAT_EN
    localparam int SUB_NEG = 0;
    localparam int ACC_W1  = 31;
    localparam int ACC_W2  = 31;
`else
    localparam int SUB_NEG = 30;
    localparam int ACC_W1  = 8;
    localparam int ACC_W2  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;
    logic [N*2-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       out_sum;
    logic [1:0]       out_ch;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    add_in_arb_pipe #(.ADD_WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ch    (out_ch),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int op;
        int a;
        int b;
        int sum;
        int ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_one(input int ch, input int op, input int a, input int b);
        in_valid = '0;
        in_valid[ch] = 1'b1;
        in_a[ch*W +: W] = a[W-1:0];
        in_b[ch*W +: W] = b[W-1:0];
        in_op[ch*2 +: 2] = op[1:0];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_one(v.ch, v.op, v.a, v.b);
        #1 chk({tag, "_ready"}, int'(in_ready), 1 << v.ch);
        @(negedge clk);
        in_valid = '0;
        chk({tag, "_lat1"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_sum"}, int'(out_sum), v.sum);
        chk({tag, "_ovf"}, int'(out_ovf), v.ovf);
        chk({tag, "_ch"}, int'(out_ch), v.ch);
    endtask

    initial begin
        int tx;
        int rx;

        vecs[0]  = '{ch: 0, op: OP_ADD, a: 9,  b: 8,  sum: 17,      ovf: 1};
        vecs[1]  = '{ch: 2, op: OP_SUB, a: 3,  b: 5,  sum: SUB_NEG, ovf: 1};
        vecs[2]  = '{ch: 3, op: OP_ADD, a: 15, b: 15, sum: 30,      ovf: 1};
        vecs[3]  = '{ch: 1, op: OP_ADD, a: 3,  b: 4,  sum: 7,       ovf: 0};
        vecs[4]  = '{ch: 0, op: OP_SUB, a: 7,  b: 7,  sum: 0,       ovf: 0};
        vecs[5]  = '{ch: 3, op: OP_SUB, a: 15, b: 0,  sum: 15,      ovf: 0};
        vecs[6]  = '{ch: 1, op: OP_LD,  a: 10, b: 0,  sum: 10,      ovf: 0};
        vecs[7]  = '{ch: 1, op: OP_ACC, a: 15, b: 7,  sum: 25,      ovf: 0};
        vecs[8]  = '{ch: 1, op: OP_ACC, a: 15, b: 0,  sum: ACC_W1,  ovf: 1};
        vecs[9]  = '{ch: 2, op: OP_ACC, a: 5,  b: 0,  sum: 5,       ovf: 0};
        vecs[10] = '{ch: 2, op: OP_LD,  a: 15, b: 15, sum: 30,      ovf: 0};
        vecs[11] = '{ch: 2, op: OP_ACC, a: 3,  b: 0,  sum: ACC_W2,  ovf: 1};

        rst       = 1'b0;
        in_valid  = '1;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        @(negedge clk);
        in_valid = '0;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pointer, then all channels request continuously.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                for (int c = 0; c < N; c++) drive_one(c, OP_ADD, c, 1);
                in_valid = '1;
            end else begin
                in_valid = '0;
            end
            #1;
            if (k < 8) chk($sformatf("rr_gnt%0d", k), int'(in_ready), 1 << (k % 4));
            if (k >= 2) begin
                chk($sformatf("rr_valid%0d", k), int'(out_valid), 1);
                chk($sformatf("rr_ch%0d", k), int'(out_ch), (k - 2) % 4);
                chk($sformatf("rr_sum%0d", k), int'(out_sum), ((k - 2) % 4) + 1);
            end
        end

        // ch0 streams while downstream stalls for 5 cycles.
        @(negedge clk);
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = (cyc >= 5);
            if (cyc == 5) chk("stall_accepted", tx, 2);
            if (out_valid) begin
                if (cyc < 5) begin
                    chk($sformatf("stall_hold_sum%0d", cyc), int'(out_sum), 1);
                    chk($sformatf("stall_busy%0d", cyc), int'(busy), 1);
                end
                if (out_ready) begin
                    chk($sformatf("stream_order%0d", rx), int'(out_sum), rx + 1);
                    rx++;
                end
            end
            if (tx < 4) drive_one(0, OP_ADD, tx + 1, 0);
            else in_valid = '0;
            #1;
            if (in_valid[0] && in_ready[0]) tx++;
        end
        chk("stream_received", rx, 4);
        in_valid = '0;
        @(negedge clk);
        chk("stream_drained", int'(busy), 0);

        // Reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b0;
        drive_one(1, OP_LD, 10, 5);
        @(negedge clk);
        drive_one(1, OP_ACC, 3, 0);
        #1 chk("inflight_accept2", int'(in_ready), 2);
        @(negedge clk);
        in_valid = '0;
        chk("inflight_busy", int'(busy), 1);
        chk("inflight_valid", int'(out_valid), 1);
        in_valid[1] = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        in_valid = '0;
        out_ready = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_quiet%0d", k), int'(out_valid), 0);
        end
        run_vec('{ch: 1, op: OP_ACC, a: 1, b: 0, sum: 1, ovf: 0}, "post_rst_acc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
